// File: rtl/dmem_if.sv
// Request/response channel between the MEM stage and dmem_ctrl.
// master drives requests; slave (the memory) returns ready and the response.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Clocked byte-addressable data memory: one request at a time, WAIT_CYCLES wait states,
// single-cycle response. Option DMEM_MISALIGN_TRAP_EN turns misaligned accesses into errors.
module dmem_ctrl #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter string       INIT_FILE   = "data_mem.txt"
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d, signed_q, signed_d, err_q, err_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [4:0]    lane_sh;
  logic [3:0]    be;
  logic          oor, misalign, acc_err, accept, commit, mem_we;
  logic [31:0]   wshift, rword, rshift, load_data;

  // Access decode works from the latched request fields.
  always_comb begin
    word_idx = addr_q[AW+1:2];
    oor      = |addr_q[31:AW+2];
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((size_q == 2'b01) && addr_q[0]) || ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    acc_err  = oor | (size_q == 2'b11) | misalign;
    case (size_q)
      2'b00: begin
        lane = addr_q[1:0];
        be   = 4'b0001 << lane;
      end
      2'b01: begin
        lane = {addr_q[1], 1'b0};
        be   = 4'b0011 << lane;
      end
      default: begin
        lane = 2'b00;
        be   = 4'b1111;
      end
    endcase
    lane_sh = {lane, 3'b000};
    wshift  = wdata_q << lane_sh;
    rword   = mem_q[word_idx];
    rshift  = rword >> lane_sh;
    case (size_q)
      2'b00:   load_data = {{24{signed_q & rshift[7]}}, rshift[7:0]};
      2'b01:   load_data = {{16{signed_q & rshift[15]}}, rshift[15:0]};
      default: load_data = rshift;
    endcase
    commit = (state_q == StBusy) && (cnt_q == 4'd0);
    mem_we = commit && we_q && !acc_err;
  end

  // Ready stays high in RESP so a new request can be taken on the edge leaving it.
  assign bus.req_ready  = (state_q != StBusy);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign accept         = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    signed_d = signed_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StBusy;
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StResp;
          rdata_d = (we_q || acc_err) ? 32'd0 : load_data;
          err_d   = acc_err;
        end
      end
      StResp: begin
        state_d = accept ? StBusy : StIdle;
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      we_d     = bus.req_we;
      signed_d = bus.req_signed;
      size_d   = bus.req_size;
      addr_d   = bus.req_addr;
      wdata_d  = bus.req_wdata;
      cnt_d    = WAIT_CYCLES[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      signed_q <= signed_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wshift[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl against a byte-array reference model.
module tb_dmem_ctrl;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned W     = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_if bus ();

  dmem_ctrl #(
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(W),
    .INIT_FILE  ("")
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  model [64];
  logic [31:0] got_rdata;
  logic        got_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: bytes live at their byte address; accesses are n aligned bytes.
  function automatic void model_access(input logic we, input logic [1:0] size, input logic sgn,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
    int n;
    int base;
    rdata = 32'd0;
    err   = (addr >= DEPTH * 4) || (size == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (size == 2'b01 && addr % 2 != 0) err = 1'b1;
    if (size == 2'b10 && addr % 4 != 0) err = 1'b1;
`endif
    if (err) return;
    n    = 1 << size;
    base = int'(addr) - int'(addr) % n;
    for (int i = 0; i < n; i++) begin
      if (we) model[base + i] = wdata[8*i +: 8];
      else    rdata[8*i +: 8] = model[base + i];
    end
    if (!we && sgn && n < 4 && rdata[8*n-1]) rdata = rdata | (32'hFFFF_FFFF << (8 * n));
    if (we) rdata = 32'd0;
  endfunction

  task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  // Called just after the accept edge; returns at the negedge inside the response cycle.
  task automatic wait_resp(input logic [31:0] exp_rdata, input logic exp_err);
    int lat  = 0;
    bit seen = 1'b0;
    for (int k = 1; k <= int'(W) + 6 && !seen; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        check("ready_busy", {31'd0, bus.req_ready}, 32'd0);
      end
    end
    check("resp_latency", lat, W + 2);
    if (seen) begin
      got_rdata = bus.resp_rdata;
      got_err   = bus.resp_err;
      check("rdata", got_rdata, exp_rdata);
      check("err", {31'd0, got_err}, {31'd0, exp_err});
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] er;
    logic        ee;
    @(negedge clk);
    check("ready_idle", {31'd0, bus.req_ready}, 32'd1);
    drive(we, size, sgn, addr, wdata);
    @(posedge clk);
    #1;
    // Scramble fields after accept: only the accept-edge values may matter.
    drive(~we, size, ~sgn, $urandom, $urandom);
    bus.req_valid = 1'b0;
    model_access(we, size, sgn, addr, wdata, er, ee);
    wait_resp(er, ee);
    @(negedge clk);
    check("resp_pulse", {31'd0, bus.resp_valid}, 32'd0);
    check("rdata_clr", bus.resp_rdata, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] er;
    logic        ee;
    logic [31:0] w0;
    int          acc_k;
    bus.req_valid = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    check("rst_err", {31'd0, bus.resp_err}, 32'd0);

    for (int w = 0; w < 16; w++) xact(1'b1, 2'b10, 1'b0, w * 4, $urandom);

    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("ld_deadbeef", got_rdata, 32'hDEAD_BEEF);
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
    xact(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080);
    xact(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lb_signed", got_rdata, 32'hFFFF_FF80);
    xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lb_unsigned", got_rdata, 32'h0000_0080);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_merged", got_rdata, 32'h8022_3344);

    xact(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    check("oor_err", {31'd0, got_err}, 32'd1);
    xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    w0 = got_rdata;
    xact(1'b1, 2'b10, 1'b0, 32'h1000, ~w0);
    xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    check("oor_no_write", got_rdata, w0);
    xact(1'b0, 2'b11, 1'b0, 32'h4, 32'h0);
    check("size11_err", {31'd0, got_err}, 32'd1);

    xact(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
    check("lh_aligned_err", {31'd0, got_err}, 32'd0);
    xact(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lh_mis_err", {31'd0, got_err}, 32'd1);
`else
    check("lh_mis_upper", got_rdata, {16'd0, w0[31:16]});
`endif

    // Request held valid through BUSY: next accept only on the edge leaving RESP.
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    model_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, er, ee);
    wait_resp(er, ee);
    check("ready_in_resp", {31'd0, bus.req_ready}, 32'd1);
    drive(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    model_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, er, ee);
    wait_resp(er, ee);
    acc_k = 0;
    @(negedge clk);

    // Reset during BUSY drops the store.
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5_A5A5);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort_valid", {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < int'(W) + 3; k++) begin
      @(negedge clk);
      if (bus.resp_valid) acc_k++;
    end
    check("abort_no_resp", acc_k, 32'd0);
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    for (int t = 0; t < 150; t++) begin
      int          r;
      logic [1:0]  sz;
      logic [31:0] a;
      r  = $urandom_range(0, 15);
      sz = (r < 2) ? 2'b11 : 2'($urandom_range(0, 2));
      if (r == 15)      a = 32'h1000 + $urandom_range(0, 255);
      else if (r == 14) a = $urandom | 32'h8000_0000;
      else              a = $urandom_range(0, 63);
      xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
